pipe_event_counter: RTL and testbench
=====================================

// Module: pipe_event_counter
// PURPOSE
//  Synthesizable pipeline event monitor that replaces bench-side cycle/stall/flush bookkeeping.
//  Counts elapsed cycles plus N_EVT single-bit event strobes (stall, flush, branch, ...) from the CPU.
//  Supports an optional cycle limit, sticky overflow flags and an indexed, registered read port.
//  Sits beside CPU in the top level; hazard/flush strobes are wired in as evt_i bits.
// PARAMETERS
//  N_EVT     4   number of event channels (1..16)
//  CNT_W     32  width of every counter, including the cycle counter (8..64)
//  SAT_MODE  1   1: counters saturate at all-ones; 0: counters wrap to 0
//  SEL_W     $clog2(N_EVT+1)  read-select width (derived; do not override)
// PORTS
//  clk_i        in   1        clock; all logic on the rising edge
//  rst_i        in   1        synchronous, active-high reset
//  start_i      in   1        count enable (level); low pauses counting
//  clr_i        in   1        synchronous clear of counters, flags and FSM
//  evt_i        in   N_EVT    event strobes; bit k high = count 1 on channel k this cycle
//  cyc_limit_i  in   CNT_W    cycle limit; 0 = unlimited; sampled every cycle
//  snap_i       in   1        snapshot request (used only with PERF_SNAPSHOT_EN)
//  rd_sel_i     in   SEL_W    0 = cycle counter, k = event counter k-1
//  rd_data_o    out  CNT_W    registered read data
//  cycle_o      out  CNT_W    live cycle count
//  ovf_o        out  N_EVT+1  sticky overflow; bit 0 = cycle, bit k = event k-1
//  run_o        out  1        high in RUN
//  done_o       out  1        high in HALT (limit reached)
// BEHAVIOUR
//  - Reset: all counters 0, ovf_o 0, rd_data_o 0, run_o 0, done_o 0, FSM in IDLE.
//  - Priority: rst_i > clr_i > counting. clr_i acts like reset but does not clear rd_data_o.
//    An event arriving in the same cycle as clr_i is dropped.
//  - FSM states: IDLE, RUN, HALT.
//    IDLE -> RUN when start_i=1. RUN -> IDLE when start_i=0 (pause; counts hold).
//    RUN -> HALT when cyc_limit_i!=0 and the incremented cycle count == cyc_limit_i.
//    HALT holds until clr_i or rst_i; start_i is ignored in HALT.
//  - RUN counting: the cycle counter does +1 every RUN cycle. Counter k does +1 when evt_i[k]=1.
//    All channels update in parallel; no cross-channel priority.
//    Events are counted on the cycle that enters HALT, and are not counted in IDLE or HALT.
//  - Overflow: an increment from all-ones sets ovf bit (sticky until clr/rst).
//    SAT_MODE=1: value holds at all-ones. SAT_MODE=0: value wraps to 0.
//  - Read: rd_data_o <= selected counter one cycle after rd_sel_i is sampled (latency 1).
//    It reflects the register value before that edge's increment.
//    rd_sel_i > N_EVT -> rd_data_o = 0.
//  - cycle_o, run_o, done_o are registered state outputs (no combinational paths from inputs).
//  - Reset or clr_i asserted mid-RUN: the next cycle is IDLE with all counts at zero.
// CONFIGURATION
//  PERF_SNAPSHOT_EN defined:
//    - Adds a shadow register bank (N_EVT+1 x CNT_W, reset to 0).
//    - snap_i=1 copies all live counter values (pre-increment) into the shadow bank in one cycle.
//    - rd_data_o reads the shadow bank; live counting is not disturbed.
//    - clr_i also zeroes the shadow bank.
//  PERF_SNAPSHOT_EN undefined: snap_i ignored; rd_data_o reads live counters; no shadow flops.
// STRUCTURE
//  - Package perf_pkg: perf_state_t enum {IDLE, RUN, HALT}; constants MAX_EVT=16,
//    SEL_IDX_CYCLE=0.
//  - Sub-module perf_cnt_slice (CNT_W, SAT_MODE):
//    ports clk_i, rst_i, clr_i, inc_i -> cnt_o, ovf_o.
//    Instantiated N_EVT+1 times via generate.
//  - Top level holds the FSM, limit compare, read mux and optional shadow bank.
// TESTING
//  1. rst_i=1 for 2 cycles -> all outputs 0, run_o=0; release with start_i=0 -> counts stay 0.
//  2. start_i=1, evt_i[0] high every 2nd cycle for 10 cycles, cyc_limit_i=0
//     -> cycle_o=10, rd_sel_i=1 gives 5 one cycle later.
//  3. cyc_limit_i=80, start_i=1 -> done_o rises when cycle_o=80 and holds 80.
//     Further evt_i pulses leave all counts unchanged; clr_i -> IDLE, all 0.
//  4. CNT_W=8, SAT_MODE=1, evt_i[1]=1 for 300 RUN cycles -> counter 1 = 255, ovf_o[2]=1.
//     Same with SAT_MODE=0 -> counter 1 = 44, ovf_o[2]=1.
//  5. clr_i and evt_i[0] both high mid-RUN -> next cycle counter 0 = 0, FSM IDLE.
//     start_i low for 3 cycles mid-RUN -> cycle_o frozen during the pause.
//  6. With PERF_SNAPSHOT_EN: snap_i at cycle_o=20, keep running to 30
//     -> rd_sel_i=0 reads 20, cycle_o=30. Without the macro -> rd_sel_i=0 reads the live value.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared types and constants for the pipeline event counter slice.
package perf_pkg;

   typedef enum logic [1:0] {IDLE, RUN, HALT} perf_state_t;

   localparam int MAX_EVT       = 16;
   localparam int SEL_IDX_CYCLE = 0;

endpackage

// File: rtl/perf_cnt_slice.sv
// One counter channel: increments on inc_i, saturates or wraps at all-ones,
// and keeps a sticky overflow flag until reset or clear.
module perf_cnt_slice
   import perf_pkg::*;
#(
   parameter int CNT_W    = 32,
   parameter int SAT_MODE = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             ovf_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;

   // An increment from all-ones is the overflow event; SAT_MODE picks hold or wrap.
   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (inc_i) begin
         if (&cnt_q) begin
            ovf_d = 1'b1;
            cnt_d = (SAT_MODE != 0) ? cnt_q : '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign cnt_o = cnt_q;
   assign ovf_o = ovf_q;

endmodule

// File: rtl/pipe_event_counter.sv
// Pipeline event monitor: cycle counter plus N_EVT event counters, run/halt FSM,
// cycle limit and registered read port. Define PERF_SNAPSHOT_EN for a shadow read bank.
module pipe_event_counter
   import perf_pkg::*;
#(
   parameter  int N_EVT    = 4,
   parameter  int CNT_W    = 32,
   parameter  int SAT_MODE = 1,
   localparam int SEL_W    = $clog2(N_EVT + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             clr_i,
   input  logic [N_EVT-1:0] evt_i,
   input  logic [CNT_W-1:0] cyc_limit_i,
   input  logic             snap_i,
   input  logic [SEL_W-1:0] rd_sel_i,
   output logic [CNT_W-1:0] rd_data_o,
   output logic [CNT_W-1:0] cycle_o,
   output logic [N_EVT:0]   ovf_o,
   output logic             run_o,
   output logic             done_o
);

   perf_state_t      state_q, state_d;
   logic             countEn;
   logic             limitHit;
   logic [N_EVT:0]   incVec;
   logic [N_EVT:0]   ovfVec;
   logic [CNT_W-1:0] cnt     [N_EVT+1];
   logic [CNT_W-1:0] rdSrc   [N_EVT+1];
   logic [CNT_W-1:0] cycleInc;
   logic [CNT_W-1:0] rdMux;
   logic [CNT_W-1:0] rdData_q;

   // Counting only happens while running with the enable still held high.
   assign countEn  = (state_q == RUN) && start_i;
   assign incVec   = {evt_i & {N_EVT{countEn}}, countEn};
   assign cycleInc = cnt[SEL_IDX_CYCLE] + CNT_W'(1);
   assign limitHit = (cyc_limit_i != '0) && (cycleInc == cyc_limit_i);

   for (genvar g = 0; g <= N_EVT; g++) begin : gSlice
      perf_cnt_slice #(
         .CNT_W    (CNT_W),
         .SAT_MODE (SAT_MODE)
      ) uSlice (
         .clk_i (clk_i),
         .rst_i (rst_i),
         .clr_i (clr_i),
         .inc_i (incVec[g]),
         .cnt_o (cnt[g]),
         .ovf_o (ovfVec[g])
      );
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i) state_d = RUN;
         RUN: begin
            if (!start_i) begin
               state_d = IDLE;
            end else if (limitHit) begin
               state_d = HALT;
            end
         end
         HALT:    state_d = HALT;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      run_o  = (state_q == RUN);
      done_o = (state_q == HALT);
   end

`ifdef PERF_SNAPSHOT_EN
   logic [CNT_W-1:0] shadow_q [N_EVT+1];

   // Shadow bank captures pre-increment live values so reads see a coherent set.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         for (int i = 0; i <= N_EVT; i++) shadow_q[i] <= '0;
      end else if (snap_i) begin
         for (int i = 0; i <= N_EVT; i++) shadow_q[i] <= cnt[i];
      end
   end

   assign rdSrc = shadow_q;
`else
   logic unusedSnap;

   assign unusedSnap = snap_i;
   assign rdSrc      = cnt;
`endif

   // Out-of-range selects fall through to zero.
   always_comb begin
      rdMux = '0;
      for (int i = 0; i <= N_EVT; i++) begin
         if (rd_sel_i == SEL_W'(i)) rdMux = rdSrc[i];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdData_q <= '0;
      end else begin
         rdData_q <= rdMux;
      end
   end

   assign rd_data_o = rdData_q;
   assign cycle_o   = cnt[SEL_IDX_CYCLE];
   assign ovf_o     = ovfVec;

endmodule

// File: tb/tb_pipe_event_counter.sv
// Random plus directed bench for pipe_event_counter: a saturating and a wrapping
// 8-bit instance share stimulus and are checked every cycle against a behavioural model.
module tb_pipe_event_counter;

   localparam int NE   = 4;
   localparam int MASK = 255;

   typedef enum {M_IDLE, M_RUN, M_HALT} modeT;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clr = 1'b0;
   logic       start = 1'b0;
   logic       snap = 1'b0;
   logic [3:0] evt = '0;
   logic [7:0] limit = '0;
   logic [2:0] sel = '0;

   logic [7:0] rdSat, rdWrap, cycleSat, cycleWrap;
   logic [4:0] ovfSat, ovfWrap;
   logic       runSat, runWrap, doneSat, doneWrap;

   int testsRun    = 0;
   int testsFailed = 0;

   int unsigned mCnt    [2][NE+1];
   bit          mOvf    [2][NE+1];
   int unsigned mShadow [2][NE+1];
   int unsigned mRd     [2];
   modeT        mMode   [2];

   always #5 clk = ~clk;

   pipe_event_counter #(.N_EVT(NE), .CNT_W(8), .SAT_MODE(1)) dutSat (
      .clk_i(clk), .rst_i(rst), .start_i(start), .clr_i(clr), .evt_i(evt),
      .cyc_limit_i(limit), .snap_i(snap), .rd_sel_i(sel), .rd_data_o(rdSat),
      .cycle_o(cycleSat), .ovf_o(ovfSat), .run_o(runSat), .done_o(doneSat)
   );

   pipe_event_counter #(.N_EVT(NE), .CNT_W(8), .SAT_MODE(0)) dutWrap (
      .clk_i(clk), .rst_i(rst), .start_i(start), .clr_i(clr), .evt_i(evt),
      .cyc_limit_i(limit), .snap_i(snap), .rd_sel_i(sel), .rd_data_o(rdWrap),
      .cycle_o(cycleWrap), .ovf_o(ovfWrap), .run_o(runWrap), .done_o(doneWrap)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Counter d is saturating for d==0 and wrapping for d==1.
   function automatic void bump(input int d, input int k);
      if (mCnt[d][k] == MASK) begin
         mOvf[d][k] = 1'b1;
         if (d == 1) mCnt[d][k] = 0;
      end else begin
         mCnt[d][k] = mCnt[d][k] + 1;
      end
   endfunction

   // Model of one clock edge from the current inputs.
   function automatic void modelStep();
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            for (int k = 0; k <= NE; k++) begin
               mCnt[d][k] = 0; mOvf[d][k] = 0; mShadow[d][k] = 0;
            end
            mRd[d]   = 0;
            mMode[d] = M_IDLE;
         end else begin
            int unsigned rdNext = 0;
            int unsigned idx    = int'(sel);
            if (idx <= NE) begin
`ifdef PERF_SNAPSHOT_EN
               rdNext = mShadow[d][idx];
`else
               rdNext = mCnt[d][idx];
`endif
            end
            if (clr) begin
               for (int k = 0; k <= NE; k++) begin
                  mCnt[d][k] = 0; mOvf[d][k] = 0; mShadow[d][k] = 0;
               end
               mMode[d] = M_IDLE;
            end else begin
`ifdef PERF_SNAPSHOT_EN
               if (snap) for (int k = 0; k <= NE; k++) mShadow[d][k] = mCnt[d][k];
`endif
               if (mMode[d] == M_RUN && start) begin
                  bit hit = (limit != 0) && (((mCnt[d][0] + 1) % 256) == int'(limit));
                  bump(d, 0);
                  for (int k = 0; k < NE; k++) if (evt[k]) bump(d, k + 1);
                  if (hit) mMode[d] = M_HALT;
               end else if (mMode[d] == M_RUN) begin
                  mMode[d] = M_IDLE;
               end else if (mMode[d] == M_IDLE && start) begin
                  mMode[d] = M_RUN;
               end
            end
            mRd[d] = rdNext;
         end
      end
   endfunction

   function automatic logic [4:0] expOvf(input int d);
      logic [4:0] v;
      for (int k = 0; k <= NE; k++) v[k] = mOvf[d][k];
      return v;
   endfunction

   task automatic checkAll();
      checkOutput("sat_cycle", cycleSat, mCnt[0][0]);
      checkOutput("sat_ovf",   ovfSat,   expOvf(0));
      checkOutput("sat_run",   runSat,   mMode[0] == M_RUN);
      checkOutput("sat_done",  doneSat,  mMode[0] == M_HALT);
      checkOutput("sat_rd",    rdSat,    mRd[0]);
      checkOutput("wrap_cycle", cycleWrap, mCnt[1][0]);
      checkOutput("wrap_ovf",   ovfWrap,   expOvf(1));
      checkOutput("wrap_run",   runWrap,   mMode[1] == M_RUN);
      checkOutput("wrap_done",  doneWrap,  mMode[1] == M_HALT);
      checkOutput("wrap_rd",    rdWrap,    mRd[1]);
   endtask

   task automatic applyStimulus(input bit r, input bit c, input bit s, input logic [3:0] e,
                                input logic [7:0] lim, input bit sn, input logic [2:0] sl);
      @(negedge clk);
      rst = r; clr = c; start = s; evt = e; limit = lim; snap = sn; sel = sl;
      @(posedge clk);
      modelStep();
      #1;
      checkAll();
   endtask

   initial begin
      int          guard;
      int unsigned held;
      logic [7:0]  curLimit;

      // Reset, then idle with start low.
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      checkOutput("reset_run", runSat, 0);
      repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("idle_cycle", cycleSat, 0);

      // Ten RUN cycles with evt[0] on alternate cycles.
      applyStimulus(0, 0, 1, 0, 0, 0, 1);
      for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, (i % 2 == 0) ? 4'b0001 : 4'b0000, 0, 0, 1);
      checkOutput("t2_cycle", cycleSat, 10);
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      checkOutput("t2_evt0", rdSat, 5);

      // Cycle limit of 80.
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 80, 0, 1);
      guard = 0;
      while (!doneSat && guard < 200) begin
         applyStimulus(0, 0, 1, 0, 80, 0, 1);
         guard++;
      end
      checkOutput("t3_done", doneSat, 1);
      checkOutput("t3_cycle", cycleSat, 80);
      repeat (5) applyStimulus(0, 0, 1, 4'hF, 80, 0, 1);
      checkOutput("t3_cycle_hold", cycleSat, 80);
      checkOutput("t3_evt_frozen", rdSat, 0);
      applyStimulus(0, 1, 1, 4'hF, 80, 0, 1);
      checkOutput("t3_clr_done", doneSat, 0);
      checkOutput("t3_clr_cycle", cycleSat, 0);

      // 300 events on channel 1: saturate versus wrap.
      applyStimulus(0, 1, 0, 0, 0, 0, 2);
      applyStimulus(0, 0, 1, 0, 0, 0, 2);
      repeat (300) applyStimulus(0, 0, 1, 4'b0010, 0, 0, 2);
      applyStimulus(0, 0, 0, 0, 0, 0, 2);
      checkOutput("t4_sat_cnt1", rdSat, 255);
      checkOutput("t4_wrap_cnt1", rdWrap, 44);
      checkOutput("t4_sat_ovf", ovfSat[2], 1);
      checkOutput("t4_wrap_ovf", ovfWrap[2], 1);

      // Clear colliding with an event, then a pause.
      applyStimulus(0, 1, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 1, 0, 0, 0, 1);
      repeat (4) applyStimulus(0, 0, 1, 4'b0001, 0, 0, 1);
      applyStimulus(0, 1, 1, 4'b0001, 0, 0, 1);
      checkOutput("t5_clr_run", runSat, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      checkOutput("t5_clr_cnt0", rdSat, 0);
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      repeat (5) applyStimulus(0, 0, 1, 0, 0, 0, 0);
      held = mCnt[0][0];
      repeat (3) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 0);
         checkOutput("t5_pause", cycleSat, held);
      end

      // Snapshot at cycle 20, read after reaching 30.
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      repeat (20) applyStimulus(0, 0, 1, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 0, 1, 0);
      repeat (9) applyStimulus(0, 0, 1, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
`ifdef PERF_SNAPSHOT_EN
      checkOutput("t6_snap_rd", rdSat, 20);
`else
      checkOutput("t6_live_rd", rdSat, 30);
`endif
      checkOutput("t6_cycle", cycleSat, 30);

      // Random traffic with a slowly changing limit.
      curLimit = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) == 0)
            curLimit = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 49) == 0,
                       $urandom_range(0, 9) != 0, 4'($urandom), curLimit,
                       $urandom_range(0, 19) == 0, 3'($urandom_range(0, 7)));
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
